// File: rtl/texture_port_arbiter.sv
// Two-port arbiter for a shared pipelined texture generator: port 0 (display) has fixed priority,
// port 1 gets a forced grant after MAX_WAIT denials. Optional stats via TEXTURE_ARB_STATS_EN.
module texture_port_arbiter #(
    parameter int TEX_LATENCY = 1,
    parameter int MAX_WAIT    = 8
) (
    input  logic        clk,
    input  logic        reset,
    // valid/ready: reqN is held with stable xN/yN until gntN; req & gnt in one cycle is an accept.
    input  logic        req0,
    input  logic [6:0]  x0,
    input  logic [6:0]  y0,
    output logic        gnt0,
    output logic        vld0,
    output logic [15:0] data0,
    input  logic        req1,
    input  logic [6:0]  x1,
    input  logic [6:0]  y1,
    output logic        gnt1,
    output logic        vld1,
    output logic [15:0] data1,
    output logic [6:0]  tex_x,
    output logic [6:0]  tex_y,
    input  logic [15:0] tex_data,
    output logic [15:0] stall_count
);

    generate
        if (TEX_LATENCY < 1) begin : g_bad_latency
            $error("TEX_LATENCY must be at least 1");
        end
        if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
            $error("MAX_WAIT must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0]             r_wait_cnt;
    logic                   w_force;
    logic                   w_gnt0;
    logic                   w_gnt1;
    logic [TEX_LATENCY-1:0] r_tag_vld;
    logic [TEX_LATENCY-1:0] r_tag_port;
    logic                   r_vld0;
    logic                   r_vld1;
    logic [15:0]            r_data0;
    logic [15:0]            r_data1;
    logic                   w_last_vld;
    logic                   w_last_port;

    always_comb begin
        w_force = req1 & (r_wait_cnt == MAX_WAIT_C);
        w_gnt1  = ~reset & req1 & (w_force | ~req0);
        w_gnt0  = ~reset & req0 & ~w_gnt1;
    end

    assign gnt0  = w_gnt0;
    assign gnt1  = w_gnt1;
    // Idle cycles present port 0 coordinates so the display scan sees no mux glitches.
    assign tex_x = w_gnt1 ? x1 : x0;
    assign tex_y = w_gnt1 ? y1 : y0;

    always_ff @(posedge clk) begin
        if (reset || w_gnt1 || !req1) begin
            r_wait_cnt <= 8'd0;
        end else if (r_wait_cnt != MAX_WAIT_C) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Tag shift register tracks which port owns each texel travelling through the generator.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_vld  <= '0;
            r_tag_port <= '0;
        end else begin
            r_tag_vld[0]  <= w_gnt0 | w_gnt1;
            r_tag_port[0] <= w_gnt1;
            for (int i = 1; i < TEX_LATENCY; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_port[i] <= r_tag_port[i-1];
            end
        end
    end

    assign w_last_vld  = r_tag_vld[TEX_LATENCY-1];
    assign w_last_port = r_tag_port[TEX_LATENCY-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld0  <= 1'b0;
            r_vld1  <= 1'b0;
            r_data0 <= 16'h0000;
            r_data1 <= 16'h0000;
        end else begin
            r_vld0 <= w_last_vld & ~w_last_port;
            r_vld1 <= w_last_vld & w_last_port;
            if (w_last_vld && !w_last_port) begin
                r_data0 <= tex_data;
            end
            if (w_last_vld && w_last_port) begin
                r_data1 <= tex_data;
            end
        end
    end

    assign vld0  = r_vld0;
    assign vld1  = r_vld1;
    assign data0 = r_data0;
    assign data1 = r_data1;

`ifdef TEXTURE_ARB_STATS_EN
    logic [15:0] r_stall_count;

    // Counts cycles where the display port was displaced by the starvation guard.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 16'h0000;
        end else if (req0 && w_force && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'h0001;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_texture_port_arbiter.sv
// Bench for texture_port_arbiter: vector table, directed multi-cycle sequences, and a
// scoreboard of {port, texel} entries checked whenever vld0/vld1 pulses.
module tb_texture_port_arbiter;

  localparam int SB_W = 17;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [6:0]  x0, y0, x1, y1;
  logic        gnt0, gnt1, vld0, vld1;
  logic [15:0] data0, data1;
  logic [6:0]  tex_x, tex_y;
  logic [15:0] tex_data;
  logic [15:0] stall_count;

  int n_cmp;
  int n_fail;
  logic [SB_W-1:0] exp_q[$];

  typedef struct {
    logic       r0;
    logic [6:0] a0;
    logic [6:0] b0;
    logic       r1;
    logic [6:0] a1;
    logic [6:0] b1;
    logic       g0;
    logic       g1;
    logic [6:0] tx;
    logic [6:0] ty;
  } vec_t;

  vec_t vecs[8];

  texture_port_arbiter #(.TEX_LATENCY(1), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .x0(x0), .y0(y0), .gnt0(gnt0), .vld0(vld0), .data0(data0),
    .req1(req1), .x1(x1), .y1(y1), .gnt1(gnt1), .vld1(vld1), .data1(data1),
    .tex_x(tex_x), .tex_y(tex_y), .tex_data(tex_data), .stall_count(stall_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] tex_fn(input logic [6:0] y);
    return ((y % 7'd6) < 7'd4) ? 16'h9A00 : 16'h5940;
  endfunction

  // shared floor texture generator, one registered stage
  always_ff @(posedge clk) tex_data <= tex_fn(tex_y);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [6:0] a0, input logic [6:0] b0,
                       input logic r1, input logic [6:0] a1, input logic [6:0] b1);
    req0 = r0; x0 = a0; y0 = b0;
    req1 = r1; x1 = a1; y1 = b1;
  endtask

  task automatic push_exp(input logic port, input logic [6:0] y);
    exp_q.push_back({port, tex_fn(y)});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      drive(1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [SB_W-1:0] e;
    if (vld0 && vld1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL vld_exclusive: got vld0=1 vld1=1 expected at most one at %0t", $time);
    end else if (vld0 || vld1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_vld: got vld0=%0b vld1=%0b expected none at %0t", vld0, vld1, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_port", {31'd0, vld1}, {31'd0, e[16]});
        check("sb_data", {16'd0, (vld1 ? data1 : data0)}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    logic [15:0] exp_stall;
    int g;
    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{1'b1, 7'd10,  7'd2,   1'b0, 7'd0,  7'd0,  1'b1, 1'b0, 7'd10,  7'd2};
    vecs[1] = '{1'b0, 7'd0,   7'd0,   1'b1, 7'd40, 7'd5,  1'b0, 1'b1, 7'd40,  7'd5};
    vecs[2] = '{1'b0, 7'd3,   7'd4,   1'b0, 7'd50, 7'd50, 1'b0, 1'b0, 7'd3,   7'd4};
    vecs[3] = '{1'b1, 7'd20,  7'd6,   1'b1, 7'd21, 7'd11, 1'b1, 1'b0, 7'd20,  7'd6};
    vecs[4] = '{1'b1, 7'd22,  7'd10,  1'b1, 7'd21, 7'd11, 1'b1, 1'b0, 7'd22,  7'd10};
    vecs[5] = '{1'b0, 7'd23,  7'd1,   1'b1, 7'd21, 7'd11, 1'b0, 1'b1, 7'd21,  7'd11};
    vecs[6] = '{1'b1, 7'd127, 7'd127, 1'b0, 7'd9,  7'd9,  1'b1, 1'b0, 7'd127, 7'd127};
    vecs[7] = '{1'b0, 7'd5,   7'd5,   1'b1, 7'd0,  7'd0,  1'b0, 1'b1, 7'd0,   7'd0};

    // reset state, with both requests asserted to prove grants are blocked
    reset = 1'b1;
    drive(1'b1, 7'd1, 7'd1, 1'b1, 7'd2, 7'd2);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_gnt0", {31'd0, gnt0}, 32'd0);
    check("rst_gnt1", {31'd0, gnt1}, 32'd0);
    check("rst_vld", {30'd0, vld0, vld1}, 32'd0);
    check("rst_data0", {16'd0, data0}, 32'd0);
    check("rst_data1", {16'd0, data1}, 32'd0);
    check("rst_stall", {16'd0, stall_count}, 32'd0);
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);

    // table-driven single-cycle vectors
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      drive(vecs[i].r0, vecs[i].a0, vecs[i].b0, vecs[i].r1, vecs[i].a1, vecs[i].b1);
      if (vecs[i].g0) push_exp(1'b0, vecs[i].b0);
      if (vecs[i].g1) push_exp(1'b1, vecs[i].b1);
      @(negedge clk);
      check($sformatf("vec%0d_gnt0", i), {31'd0, gnt0}, {31'd0, vecs[i].g0});
      check($sformatf("vec%0d_gnt1", i), {31'd0, gnt1}, {31'd0, vecs[i].g1});
      check($sformatf("vec%0d_tex_x", i), {25'd0, tex_x}, {25'd0, vecs[i].tx});
      check($sformatf("vec%0d_tex_y", i), {25'd0, tex_y}, {25'd0, vecs[i].ty});
    end
    idle_cycles(4);

    // port 0 only: vld0 exactly in cycle 2
    next_cycle();
    drive(1'b1, 7'd10, 7'd2, 1'b0, 7'd0, 7'd0);
    push_exp(1'b0, 7'd2);
    @(negedge clk);
    check("p0_gnt0", {31'd0, gnt0}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      drive(1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
      @(negedge clk);
      check($sformatf("p0_vld0_c%0d", c), {31'd0, vld0}, (c == 2) ? 32'd1 : 32'd0);
      check($sformatf("p0_vld1_c%0d", c), {31'd0, vld1}, 32'd0);
    end
    check("p0_data0_hold", {16'd0, data0}, 32'h9A00);

    // port 1 only
    next_cycle();
    drive(1'b0, 7'd0, 7'd0, 1'b1, 7'd40, 7'd5);
    push_exp(1'b1, 7'd5);
    @(negedge clk);
    check("p1_gnt1", {31'd0, gnt1}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      drive(1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
      @(negedge clk);
      check($sformatf("p1_vld1_c%0d", c), {31'd0, vld1}, (c == 2) ? 32'd1 : 32'd0);
    end
    check("p1_data1_hold", {16'd0, data1}, 32'h5940);

    // streaming: back-to-back accepts give back-to-back vld0
    for (int c = 0; c <= 8; c++) begin
      next_cycle();
      if (c <= 5) begin
        drive(1'b1, 7'(c + 30), 7'(c), 1'b0, 7'd0, 7'd0);
        push_exp(1'b0, 7'(c));
      end else begin
        drive(1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
      end
      @(negedge clk);
      check($sformatf("stream_vld0_c%0d", c), {31'd0, vld0}, (c >= 2 && c <= 7) ? 32'd1 : 32'd0);
      if (c == 6) check("stream_data0_c6", {16'd0, data0}, 32'h5940);
    end
    idle_cycles(2);

    // full contention for 27 cycles, MAX_WAIT=8
    for (int c = 0; c < 27; c++) begin
      g = c / 9;
      next_cycle();
      drive(1'b1, 7'(c), 7'(c % 16), 1'b1, 7'd60, 7'(4 + g));
      if ((c % 9) == 8) push_exp(1'b1, 7'(4 + g));
      else              push_exp(1'b0, 7'(c % 16));
      @(negedge clk);
      check($sformatf("cont_gnt1_c%0d", c), {31'd0, gnt1}, ((c % 9) == 8) ? 32'd1 : 32'd0);
      check($sformatf("cont_gnt0_c%0d", c), {31'd0, gnt0}, ((c % 9) == 8) ? 32'd0 : 32'd1);
      check($sformatf("cont_vld1_c%0d", c), {31'd0, vld1}, (c == 10 || c == 19) ? 32'd1 : 32'd0);
    end
    next_cycle();
    drive(1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
    @(negedge clk);
`ifdef TEXTURE_ARB_STATS_EN
    exp_stall = 16'd3;
`else
    exp_stall = 16'd0;
`endif
    check("stall_count", {16'd0, stall_count}, {16'd0, exp_stall});
    idle_cycles(4);
    check("queue_drained_mid", exp_q.size(), 32'd0);

    // reset mid-flight: pre-reset accept must never produce vld0
    next_cycle();
    drive(1'b1, 7'd10, 7'd4, 1'b0, 7'd0, 7'd0);
    @(negedge clk);
    check("rmf_gnt0_c0", {31'd0, gnt0}, 32'd1);
    next_cycle();
    reset = 1'b1;
    drive(1'b1, 7'd10, 7'd4, 1'b1, 7'd5, 7'd5);
    @(negedge clk);
    check("rmf_gnt0_rst", {31'd0, gnt0}, 32'd0);
    check("rmf_gnt1_rst", {31'd0, gnt1}, 32'd0);
    next_cycle();
    reset = 1'b0;
    drive(1'b1, 7'd11, 7'd0, 1'b0, 7'd0, 7'd0);
    push_exp(1'b0, 7'd0);
    @(negedge clk);
    check("rmf_gnt0_resume", {31'd0, gnt0}, 32'd1);
    check("rmf_vld0_c2", {31'd0, vld0}, 32'd0);
    check("rmf_data0_c2", {16'd0, data0}, 32'd0);
    next_cycle();
    drive(1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 7'd0);
    @(negedge clk);
    check("rmf_vld0_c3", {31'd0, vld0}, 32'd0);
    check("rmf_data0_c3", {16'd0, data0}, 32'd0);
    check("rmf_stall_cleared", {16'd0, stall_count}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("rmf_vld0_c4", {31'd0, vld0}, 32'd1);
    idle_cycles(4);

    check("queue_drained_end", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/texture_port_arbiter.md
Name: texture_port_arbiter

Overview:
- Shares one pipelined texture generator (96x64 OLED texel source, 16-bit RGB565, registered output) between two requesters.
- Port 0 is the display path, driven by the OLED pixel scan. Port 1 is game logic, e.g. collision or minimap sampling of floor colour.
- Port 0 has fixed priority. A starvation guard forces a port 1 grant after MAX_WAIT consecutive denials.
- Return data is tagged through the texture pipeline and delivered with a valid pulse to the port that issued the request.

Parameters:
- TEX_LATENCY, 1, clock cycles from tex_x/tex_y sampled to tex_data valid (shared generator depth).
- MAX_WAIT, 8, consecutive denied cycles of port 1 before a forced grant; range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 request; held until granted
- x0  in  7  port 0 column
- y0  in  7  port 0 row
- gnt0  out  1  port 0 accepted this cycle (combinational)
- vld0  out  1  port 0 result valid, one-cycle pulse
- data0  out  16  port 0 texel, RGB565
- req1, x1, y1, gnt1, vld1, data1: same widths and meanings for port 1
- tex_x  out  7  column to shared texture generator
- tex_y  out  7  row to shared texture generator
- tex_data  in  16  texel from generator, valid TEX_LATENCY cycles after tex_x/tex_y
- stall_count  out  16  port 0 denials caused by forced grants (see Optional Feature)

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- Arbitration (combinational, each cycle):
  - force = req1 & (wait_cnt == MAX_WAIT).
  - gnt1 = req1 & (force | ~req0).
  - gnt0 = req0 & ~gnt1.
  - At most one grant per cycle. Both grants are 0 while reset is high.
- Accept = req & gnt in the same cycle. A requester must hold x/y stable until granted; a grant consumes the request that cycle.
- Coordinate mux: tex_x/tex_y = x1/y1 when gnt1, else x0/y0, including idle cycles. Coordinates pass unchanged (no range check); out-of-range handling belongs to the generator.
- Starvation counter wait_cnt, 8-bit:
  - Cleared on reset, on gnt1, or when req1=0.
  - Incremented when req1 & ~gnt1.
  - Never exceeds MAX_WAIT.
- Tag pipeline:
  - Shift register of TEX_LATENCY entries, each {valid, port}.
  - Stage 0 is loaded with {gnt0|gnt1, gnt1} at each edge.
  - When the last stage is valid, tex_data is registered into data0 or data1 per the port bit, and the matching vld pulses high next cycle.
- Latency: accept in cycle N gives vld high in cycle N+1+TEX_LATENCY (N+2 by default).
- Throughput: one result per cycle total; back-to-back accepts give back-to-back vld.
- data0/data1 hold their last value between pulses.
- Reset values: vld0=vld1=0, data0=data1=0, wait_cnt=0, all tag valids=0, stall_count=0.
- Reset mid-operation: all in-flight tags are discarded. No vld is asserted for any request accepted before or during reset.
- Simultaneous req0 and req1 with wait_cnt<MAX_WAIT: port 0 wins and wait_cnt increments.
- MAX_WAIT=1: grants alternate under full contention.

Optional Feature:
- Macro: TEXTURE_ARB_STATS_EN.
- When defined:
  - stall_count increments, saturating at 16'hFFFF, in every cycle where req0=1 and force=1 (port 0 displaced by the guard).
  - Cleared only by reset.
- When undefined: stall_count is tied to 16'h0000 and no counter logic is synthesised.
- Port list is identical in both builds.

Test Plan:
- Bench instantiates the shared floor texture generator: y%6<4 gives 16'h9A00, else 16'h5940.
- Port 0 only: req0=1, x0=10, y0=2 at cycle 0 -> gnt0=1 in cycle 0; vld0=1 in cycle 2 only; data0=16'h9A00; vld1 stays 0.
- Port 1 only: req1=1, x1=40, y1=5 at cycle 0 -> gnt1=1 in cycle 0; vld1=1 in cycle 2; data1=16'h5940.
- Full contention, MAX_WAIT=8, req0=req1=1 held -> gnt0 in cycles 0-7, gnt1 in cycle 8, gnt0 in 9-16, gnt1 in 17; period 9. vld1 in cycles 10 and 19 with the correct texel.
- Streaming: req0=1 with y0=0,1,2,3,4,5 in successive cycles -> vld0 high in cycles 2-7 continuously; data0 = 9A00, 9A00, 9A00, 9A00, 5940, 5940.
- Reset mid-flight: req0 accepted in cycle 0, reset=1 in cycle 1 -> vld0 never asserts; data0=0; gnt0=gnt1=0 during reset. Normal grant resumes the first cycle after reset deasserts.
- Stats: with TEXTURE_ARB_STATS_EN, run full contention for 27 cycles -> stall_count=3. Same run without the macro -> stall_count=0.
